// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - multi-channel switch debouncer with shared sample tick
// Each channel: 2-flop synchroniser, four-state qualify FSM, registered rise/fall strobes.
module multi_debounce #(
  parameter int            CH       = 4,
  parameter int            TICK_DIV = 500000,
  parameter int            STABLE   = 3,
  parameter logic [CH-1:0] INV      = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE > 0) ? $clog2(STABLE + 1) : 1;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  logic [CH-1:0] sync1_q, sync2_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [CW-1:0] cnt_q   [CH];
  logic [CW-1:0] cnt_d   [CH];
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] fall_q, fall_d;

  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ZERO: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = '0;
          end
        end
        WAIT1: begin
          // An input reversal outranks a coincident tick.
          if (!sync2_q[i]) begin
            state_d[i] = ZERO;
          end else if (tick) begin
            if (cnt_q[i] == CW'(STABLE - 1)) begin
              state_d[i] = ONE;
              rise_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        ONE: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = '0;
          end
        end
        WAIT0: begin
          if (sync2_q[i]) begin
            state_d[i] = ONE;
          end else if (tick) begin
            if (cnt_q[i] == CW'(STABLE - 1)) begin
              state_d[i] = ZERO;
              fall_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        default: begin
          state_d[i] = ZERO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sw ^ INV;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Level output is the upper state bit set: ONE or WAIT0.
  always_comb begin
    db = '0;
    for (int i = 0; i < CH; i++) begin
      db[i] = (state_q[i] == ONE) || (state_q[i] == WAIT0);
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_multi_debounce.sv
// tb/tb_multi_debounce.sv - self-checking bench for multi_debounce
// Reference model counts sample ticks during which the synchronised input disagrees with db.
module tb_multi_debounce;

  localparam int         CH       = 4;
  localparam int         TICK_DIV = 4;
  localparam int         STABLE   = 3;
  localparam logic [3:0] INV      = 4'b1000;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] db, rise, fall;

  multi_debounce #(
    .CH(CH), .TICK_DIV(TICK_DIV), .STABLE(STABLE), .INV(INV)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .db(db), .rise(rise), .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int         m_n;
  logic [3:0] m_s1, m_s2, m_db, m_rise, m_fall;
  bit         m_wait [4];
  int         m_k    [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_n = 0;
    m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < 4; i++) begin
      m_wait[i] = 0;
      m_k[i]    = 0;
    end
  endtask

  // One rising edge of the reference: a run of disagreement begins on the edge it is
  // first seen and db flips on the STABLE-th tick that follows while the run persists.
  task automatic model_edge();
    bit         tk;
    logic [3:0] ss;
    if (!rst) begin
      model_reset();
      return;
    end
    tk   = ((m_n % TICK_DIV) == TICK_DIV - 1);
    m_n++;
    ss   = m_s2;
    m_s2 = m_s1;
    m_s1 = sw ^ INV;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < 4; i++) begin
      if (ss[i] != m_db[i]) begin
        if (!m_wait[i]) begin
          m_wait[i] = 1;
          m_k[i]    = 0;
        end else if (tk) begin
          m_k[i]++;
          if (m_k[i] == STABLE) begin
            m_db[i]   = ~m_db[i];
            m_rise[i] = m_db[i];
            m_fall[i] = ~m_db[i];
            m_wait[i] = 0;
          end
        end
      end else begin
        m_wait[i] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("db", db, m_db);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic measure(input string tag, input int ch, input logic val, output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (db[ch] === val) begin
        edges = i;
        break;
      end
    end
    chk({tag, "_latency_in_12_15"}, (edges >= 12 && edges <= 15), 1);
  endtask

  int         e;
  int         cnt_r, cnt_f;
  logic [3:0] first_db;

  initial begin
    rst = 1'b0;
    sw  = 4'b1000;
    model_reset();
    #2;
    chk("reset_db", db, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);
    run(3);
    #2 rst = 1'b1;
    run(25);
    chk("inv_idle_db3", db[3], 0);

    // Clean press on ch0
    sw[0] = 1'b1;
    measure("press0", 0, 1'b1, e);
    chk("press0_rise", rise, 4'b0001);
    chk("press0_others", db[3:1], 0);
    run(5);

    // Glitch rejection on ch1
    cnt_r = 0;
    sw[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin cyc(); cnt_r += rise[1]; end
    sw[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin cyc(); cnt_r += rise[1]; end
    chk("glitch1_rise_count", cnt_r, 0);
    chk("glitch1_db", db[1], 0);
    cnt_r = 0;
    for (int b = 0; b < 4; b++) begin
      sw[1] = ~b[0];
      for (int i = 0; i < 3; i++) begin cyc(); cnt_r += rise[1]; end
    end
    sw[1] = 1'b1;
    for (int i = 0; i < 30; i++) begin cyc(); cnt_r += rise[1]; end
    chk("bounce1_rise_count", cnt_r, 1);

    // Release on ch2, then short blips during WAIT0
    sw[2] = 1'b1;
    run(25);
    sw[2] = 1'b0;
    measure("release2", 2, 1'b0, e);
    chk("release2_fall", fall, 4'b0100);
    sw[2] = 1'b1;
    run(25);
    cnt_f = 0;
    for (int b = 0; b < 3; b++) begin
      sw[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin cyc(); cnt_f += fall[2]; end
      sw[2] = 1'b1;
      for (int i = 0; i < 2; i++) begin cyc(); cnt_f += fall[2]; end
    end
    for (int i = 0; i < 20; i++) begin cyc(); cnt_f += fall[2]; end
    chk("blip2_fall_count", cnt_f, 0);
    chk("blip2_db", db[2], 1);

    // All channels rise together
    sw = 4'b1000;
    run(25);
    chk("all_low_db", db, 0);
    sw = 4'b0111;
    first_db = '0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (db !== 4'b0000) begin
        first_db = db;
        chk("all_rise_pulse", rise, 4'b1111);
        break;
      end
    end
    chk("all_first_db", first_db, 4'b1111);
    cyc();
    chk("all_rise_one_cycle", rise, 0);

    // Inversion: ch3 active-low pin
    sw = 4'b1000;
    run(25);
    sw[3] = 1'b0;
    measure("inv3", 3, 1'b1, e);
    chk("inv3_rise", rise[3], 1);
    sw = 4'b1000;
    run(25);

    // Reset while ch0 in WAIT1 and ch1 in ONE
    sw = 4'b1010;
    run(25);
    sw[0] = 1'b1;
    run(6);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("midreset_db", db, 0);
    chk("midreset_rise", rise, 0);
    chk("midreset_fall", fall, 0);
    run(3);
    rst = 1'b1;
    e = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (db[1:0] === 2'b11) begin
        e = i;
        break;
      end
    end
    chk("requal_latency_in_12_15", (e >= 12 && e <= 15), 1);
    chk("requal_rise", rise[1:0], 2'b11);

    // Random traffic against the model
    for (int seg = 0; seg < 60; seg++) begin
      sw = 4'($urandom);
      run($urandom_range(1, 16));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_debounce.md
# multi_debounce

Parametrised multi-channel switch/button debouncer for the board-input front end. It synchronises CH raw mechanical inputs and filters each with an independent four-state FSM clocked by one shared sample-tick prescaler. Each channel produces a level output plus single-cycle rise/fall strobes, so downstream FSMs no longer need their own edge detectors. It replaces per-button single-channel debouncers wherever several switches are sampled together.

## Interface
- CH, 4: number of independent channels (≥1)
- TICK_DIV, 500000: clk cycles per sample tick (≥2; 10 ms at 50 MHz)
- STABLE, 3: consecutive ticks of a constant input required to change a channel's output (≥1)
- INV, {CH{1'b0}}: per-channel inversion mask; bit i=1 means channel i is active-low at the pin
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- sw  in  CH  raw asynchronous switch inputs
- db  out  CH  debounced level per channel
- rise  out  CH  one-cycle pulse when db[i] goes 0→1
- fall  out  CH  one-cycle pulse when db[i] goes 1→0

## Operation
- Input path: s[i] = sw[i] ^ INV[i], passed through a 2-flop synchroniser → ss[i]. Only ss is used by the FSMs.
- Prescaler: one counter of width $clog2(TICK_DIV), counts 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle when count==TICK_DIV-1. Shared by all channels.
- Per channel: state ∈ {ZERO, WAIT1, ONE, WAIT0} and tick counter cnt of width $clog2(STABLE+1).
  - ZERO: ss=1 → WAIT1 with cnt=0. tick is ignored in this state.
  - WAIT1: ss=0 → ZERO. Otherwise, on tick, cnt++. When tick arrives with cnt==STABLE-1 → ONE and rise[i] is asserted.
  - ONE: ss=0 → WAIT0 with cnt=0.
  - WAIT0: ss=1 → ONE. Otherwise, on tick, cnt++. When tick arrives with cnt==STABLE-1 → ZERO and fall[i] is asserted.
  - Unreachable encodings → ZERO.
- db[i] = 1 in ONE or WAIT0, 0 in ZERO or WAIT1. It is decoded directly from the state register, so it is glitch-free.
- ss reversing while in a wait state aborts the wait. cnt restarts from 0 on the next entry.
- Channels are fully independent. Any number of channels may change in the same cycle.
- Simultaneous ss reversal and tick in a wait state: the reversal wins and the tick is ignored.

## Timing
- Reset (rst=0, asynchronous): prescaler=0, every state=ZERO, cnt=0, synchroniser flops=0, db=0, rise=0, fall=0.
  - With INV[i]=1 and the pin idle high, the channel reads 0 immediately after reset.
  - Reset release is assumed synchronised externally.
- Synchroniser latency: 2 clk. ZERO→WAIT1 on the 3rd edge after the pin change.
- Assert latency, pin stable from edge 0: db rises on an edge in the range [3+(STABLE-1)·TICK_DIV+1, 3+STABLE·TICK_DIV]. The deassert latency is identical.
- rise/fall are registered. They are high in exactly the first cycle db shows its new value, for one cycle, and are never both high on one channel.
- Pulses shorter than (STABLE-1)·TICK_DIV+1 cycles are always rejected.
- Reset asserted mid-wait or mid-pulse: all outputs go to 0 immediately, with no trailing rise/fall.

## Test plan
- Clean press, CH=4, TICK_DIV=4, STABLE=3, ch0 0→1 and held → db[0]=1 within 12..15 cycles; rise[0] high 1 cycle coinciding with db[0]'s first high cycle; db[3:1]=0, no other pulses.
- Glitch rejection: ch1 high for 6 cycles then low → db[1] stays 0, no rise[1]. Repeat bounce train 1-0-1-0 (3 cycles each) then stable 1 → rise[1] only after final stable window, exactly once.
- Release: from db[2]=1, ch2 → 0 and held → fall[2] single pulse, db[2]=0 within 12..15 cycles; 2-cycle high blip during WAIT0 returns to ONE, no fall.
- Simultaneous channels: all 4 channels rise in the same cycle → all db bits set on the same edge, rise=4'b1111 for one cycle.
- Inversion: INV=4'b1000, sw[3] held 1 through reset → db[3]=0; drive sw[3]=0 → db[3]=1 and rise[3] after 12..15 cycles.
- Reset mid-operation: assert rst=0 while ch0 is in WAIT1 and ch1 is in ONE → db, rise, fall =0 asynchronously; after release with inputs held, both re-qualify from ZERO in 12..15 cycles.
